// File: rtl/mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mmio_bridge
// Purpose  : Data-memory bridge between a processor memory stage, a
//            synchronous data RAM and a small MMIO block (LEDs, switches,
//            32-bit compare timer, bus-error status).
// Ports    : clock/reset    - master clock, async active-high reset
//            address_dmem   - processor word address
//            data, wren     - store data / store strobe
//            q_dmem         - load data, one clock after the address
//            ram_addr/ram_wdata/ram_wren/ram_q - data RAM port
//            switches, leds - board I/O
//            timer_irq      - timer interrupt level
// Revision : 1.0 - initial release
// ============================================================================
module mmio_bridge (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [11:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_wren,
    input  logic [31:0] ram_q,
    input  logic [15:0] switches,
    output logic [15:0] leds,
    output logic        timer_irq
);

    localparam logic [1:0] c_sel_ram  = 2'd0;
    localparam logic [1:0] c_sel_mmio = 2'd1;
    localparam logic [1:0] c_sel_none = 2'd2;

    localparam logic [3:0] c_off_led    = 4'd0;
    localparam logic [3:0] c_off_sw     = 4'd1;
    localparam logic [3:0] c_off_tcount = 4'd2;
    localparam logic [3:0] c_off_tcmp   = 4'd3;
    localparam logic [3:0] c_off_tctrl  = 4'd4;
    localparam logic [3:0] c_off_status = 4'd5;

    // Registered state
    logic [1:0]  r_sel;
    logic [31:0] r_mmio_rdata;
    logic [15:0] r_leds;
    logic [15:0] r_sw_meta;
    logic [15:0] r_sw_sync;
    logic [31:0] r_tcount;
    logic [31:0] r_tcmp;
    logic        r_ten;
    logic        r_tar;
    logic        r_tflag;
    logic        r_tie;
    logic        r_bus_err;

    // Address decode
    logic        w_ram_hit;
    logic        w_mmio_hit;
    logic        w_unmapped;
    logic [3:0]  w_off;
    logic        w_wr_led;
    logic        w_wr_tcmp;
    logic        w_wr_tctrl;
    logic        w_match;
    logic [31:0] w_mmio_rdata;

    assign w_ram_hit  = (address_dmem[31:12] == 20'd0);
    assign w_mmio_hit = (address_dmem[31:4] == 28'hFFF_FFFF);
    assign w_unmapped = !w_ram_hit && !w_mmio_hit;
    assign w_off      = address_dmem[3:0];

    assign w_wr_led   = wren && w_mmio_hit && (w_off == c_off_led);
    assign w_wr_tcmp  = wren && w_mmio_hit && (w_off == c_off_tcmp);
    assign w_wr_tctrl = wren && w_mmio_hit && (w_off == c_off_tctrl);

    // RAM port is a pure pass-through; only the write strobe is gated.
    assign ram_addr  = address_dmem[11:0];
    assign ram_wdata = data;
    assign ram_wren  = wren && w_ram_hit;

    // Match uses the current (pre-write) compare value.
    assign w_match = r_ten && (r_tcount == r_tcmp);

    // MMIO read mux on current register values, so a same-edge write is
    // not visible in the returned data.
    always_comb begin
        w_mmio_rdata = 32'd0;
        case (w_off)
            c_off_led:    w_mmio_rdata = {16'd0, r_leds};
            c_off_sw:     w_mmio_rdata = {16'd0, r_sw_sync};
            c_off_tcount: w_mmio_rdata = r_tcount;
            c_off_tcmp:   w_mmio_rdata = r_tcmp;
            c_off_tctrl:  w_mmio_rdata = {28'd0, r_tie, r_tflag, r_tar, r_ten};
            c_off_status: w_mmio_rdata = {31'd0, r_bus_err};
            default:      w_mmio_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sel        <= c_sel_ram;
            r_mmio_rdata <= 32'd0;
            r_leds       <= 16'd0;
            r_sw_meta    <= 16'd0;
            r_sw_sync    <= 16'd0;
            r_tcount     <= 32'd0;
            r_tcmp       <= 32'hFFFF_FFFF;
            r_ten        <= 1'b0;
            r_tar        <= 1'b0;
            r_tflag      <= 1'b0;
            r_tie        <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_sw_meta <= switches;
            r_sw_sync <= r_sw_meta;

            if (w_ram_hit)
                r_sel <= c_sel_ram;
            else if (w_mmio_hit)
                r_sel <= c_sel_mmio;
            else
                r_sel <= c_sel_none;

            r_mmio_rdata <= w_mmio_rdata;

            if (w_unmapped)
                r_bus_err <= 1'b1;

            if (w_wr_led)
                r_leds <= data[15:0];

            if (w_wr_tcmp)
                r_tcmp <= data;

            // Counter: on a match either reload to zero or freeze.
            if (r_ten) begin
                if (w_match) begin
                    if (r_tar)
                        r_tcount <= 32'd0;
                end else begin
                    r_tcount <= r_tcount + 32'd1;
                end
            end

            // A software write to TCTRL overrides the one-shot auto-disable.
            if (w_wr_tctrl)
                r_ten <= data[0];
            else if (w_match && !r_tar)
                r_ten <= 1'b0;

            if (w_wr_tctrl) begin
                r_tar <= data[1];
                r_tie <= data[3];
            end

            // Set beats write-one-to-clear on the same edge.
            if (w_match)
                r_tflag <= 1'b1;
            else if (w_wr_tctrl && data[2])
                r_tflag <= 1'b0;
        end
    end

    assign leds      = r_leds;
    assign timer_irq = r_tflag && r_tie;

    always_comb begin
        q_dmem = 32'd0;
        case (r_sel)
            c_sel_ram:  q_dmem = ram_q;
            c_sel_mmio: q_dmem = r_mmio_rdata;
            default:    q_dmem = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_bridge
// Purpose  : Self-checking bench for mmio_bridge: vector table for the
//            single-cycle bus behaviour plus hand-written timer, bus-error,
//            synchronizer and asynchronous-reset sequences. Expected load
//            data is queued when a cycle is driven and compared when the
//            bridge returns it one clock later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_bridge;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_wren;
    logic [31:0] ram_q;
    logic [15:0] switches;
    logic [15:0] leds;
    logic        timer_irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb_q[$];
    logic [31:0] mem [0:4095];

    mmio_bridge dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q),
        .switches     (switches),
        .leds         (leds),
        .timer_irq    (timer_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM model, read-before-write, one clock latency.
    always @(posedge clock) begin
        if (ram_wren)
            mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One bus cycle: drive on the falling edge, check the combinational RAM
    // port, then compare any queued load data after the rising edge.
    task automatic bus_cycle(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                             input logic chk, input logic [31:0] exp_q, input string name);
        logic [31:0] got;
        @(negedge clock);
        wren         = wr;
        address_dmem = addr;
        data         = wd;
        if (chk)
            sb_q.push_back(exp_q);
        #1;
        check({name, "_ram_wren"}, {31'd0, ram_wren}, {31'd0, wr && (addr[31:12] == 20'd0)});
        @(posedge clock);
        #1;
        if (chk) begin
            if (sb_q.size() == 0) begin
                check({name, "_sb_empty"}, 32'd1, 32'd0);
            end else begin
                got = sb_q.pop_front();
                check({name, "_q"}, q_dmem, got);
            end
        end
    endtask

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp_q;
        logic [15:0] exp_leds;
    } vec_t;

    vec_t vecs [16];

    initial begin
        // Vector table: stores also check the pre-write/old-RAM read data.
        vecs[0]  = '{1'b1, 32'hFFFF_FFF0, 32'h0000_ABCD, 1'b1, 32'h0000_0000, 16'hABCD};
        vecs[1]  = '{1'b0, 32'hFFFF_FFF0, 32'h0,         1'b1, 32'h0000_ABCD, 16'hABCD};
        vecs[2]  = '{1'b1, 32'h0000_0005, 32'h0000_1234, 1'b1, 32'h0000_0000, 16'hABCD};
        vecs[3]  = '{1'b0, 32'h0000_0005, 32'h0,         1'b1, 32'h0000_1234, 16'hABCD};
        vecs[4]  = '{1'b0, 32'hFFFF_FFF1, 32'h0,         1'b1, 32'h0000_5A5A, 16'hABCD};
        vecs[5]  = '{1'b0, 32'hFFFF_FFF2, 32'h0,         1'b1, 32'h0000_0000, 16'hABCD};
        vecs[6]  = '{1'b0, 32'hFFFF_FFF3, 32'h0,         1'b1, 32'hFFFF_FFFF, 16'hABCD};
        vecs[7]  = '{1'b0, 32'hFFFF_FFF4, 32'h0,         1'b1, 32'h0000_0000, 16'hABCD};
        vecs[8]  = '{1'b0, 32'hFFFF_FFF5, 32'h0,         1'b1, 32'h0000_0000, 16'hABCD};
        vecs[9]  = '{1'b1, 32'hFFFF_FFF8, 32'h0000_DEAD, 1'b1, 32'h0000_0000, 16'hABCD};
        vecs[10] = '{1'b0, 32'hFFFF_FFF8, 32'h0,         1'b1, 32'h0000_0000, 16'hABCD};
        vecs[11] = '{1'b1, 32'hFFFF_FFF0, 32'h1234_5678, 1'b1, 32'h0000_ABCD, 16'h5678};
        vecs[12] = '{1'b0, 32'hFFFF_FFF0, 32'h0,         1'b1, 32'h0000_5678, 16'h5678};
        vecs[13] = '{1'b1, 32'h0000_0FFF, 32'hCAFE_F00D, 1'b1, 32'h0000_0000, 16'h5678};
        vecs[14] = '{1'b0, 32'h0000_0FFF, 32'h0,         1'b1, 32'hCAFE_F00D, 16'h5678};
        vecs[15] = '{1'b0, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'h0000_0000, 16'h5678};

        for (int i = 0; i < 4096; i++)
            mem[i] = 32'd0;
        ram_q        = 32'd0;
        reset        = 1'b1;
        wren         = 1'b0;
        address_dmem = 32'd0;
        data         = 32'd0;
        switches     = 16'h5A5A;

        // Reset state, and ram_wren stays combinational during reset.
        #3;
        check("rst_leds", {16'd0, leds}, 32'd0);
        check("rst_irq", {31'd0, timer_irq}, 32'd0);
        check("rst_q", q_dmem, 32'd0);
        wren         = 1'b1;
        address_dmem = 32'h0000_0010;
        #1;
        check("rst_ram_wren", {31'd0, ram_wren}, 32'd1);
        check("rst_ram_addr", {20'd0, ram_addr}, 32'h10);
        wren = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            bus_cycle(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].chk, vecs[i].exp_q,
                      $sformatf("vec%0d", i));
            check($sformatf("vec%0d_leds", i), {16'd0, leds}, {16'd0, vecs[i].exp_leds});
        end

        // Switch synchronizer: a pin change is not visible on the next read
        // but is after two more clocks.
        @(negedge clock);
        switches = 16'h0F0F;
        bus_cycle(1'b0, 32'hFFFF_FFF1, 32'h0, 1'b1, 32'h0000_5A5A, "sw_old");
        bus_cycle(1'b0, 32'hFFFF_FFF1, 32'h0, 1'b0, 32'h0, "sw_mid");
        bus_cycle(1'b0, 32'hFFFF_FFF1, 32'h0, 1'b1, 32'h0000_0F0F, "sw_new");

        // Unmapped access: zero data, no RAM write, sticky status.
        bus_cycle(1'b0, 32'h0000_2000, 32'h0, 1'b1, 32'h0, "unmap_ld");
        bus_cycle(1'b1, 32'h0000_2005, 32'h5555_5555, 1'b1, 32'h0, "unmap_st");
        bus_cycle(1'b0, 32'hFFFF_FFF5, 32'h0, 1'b1, 32'h1, "status1");
        bus_cycle(1'b0, 32'h0000_0005, 32'h0, 1'b1, 32'h0000_1234, "ram_kept");
        bus_cycle(1'b0, 32'hFFFF_FFF5, 32'h0, 1'b1, 32'h1, "status2");

        // Auto-reload timer: TCOUNT 0,1,2,3,0,1 with flag at the 3->0 edge.
        bus_cycle(1'b1, 32'hFFFF_FFF3, 32'd3, 1'b0, 32'h0, "tcmp3");
        bus_cycle(1'b1, 32'hFFFF_FFF4, 32'hB, 1'b0, 32'h0, "tctrlB");
        for (int i = 0; i < 6; i++) begin
            bus_cycle(1'b0, 32'hFFFF_FFF2, 32'h0, 1'b1, (i == 4) ? 32'd0 : (i == 5) ? 32'd1 : i,
                      $sformatf("ar_cnt%0d", i));
            check($sformatf("ar_irq%0d", i), {31'd0, timer_irq}, {31'd0, i >= 3});
        end
        // Count is 2: W1C clears; next edge count is 3 and match beats W1C.
        bus_cycle(1'b1, 32'hFFFF_FFF4, 32'hF, 1'b1, 32'h0000_000F, "w1c");
        check("w1c_irq", {31'd0, timer_irq}, 32'd0);
        bus_cycle(1'b1, 32'hFFFF_FFF4, 32'hF, 1'b1, 32'h0000_000B, "w1c_vs_set");
        check("w1c_vs_set_irq", {31'd0, timer_irq}, 32'd1);

        // Disable (count 0->1 on this edge), then restart with irq enable
        // while the flag is still set.
        bus_cycle(1'b1, 32'hFFFF_FFF4, 32'h0, 1'b0, 32'h0, "dis");
        bus_cycle(1'b1, 32'hFFFF_FFF3, 32'd100, 1'b0, 32'h0, "tcmp100");
        bus_cycle(1'b1, 32'hFFFF_FFF4, 32'h9, 1'b0, 32'h0, "tctrl9");
        for (int i = 0; i < 4; i++)
            bus_cycle(1'b0, 32'hFFFF_FFF2, 32'h0, 1'b1, i + 1, $sformatf("pre_rst%0d", i));
        check("pre_rst_irq", {31'd0, timer_irq}, 32'd1);

        // Asynchronous reset mid-count (TCOUNT is now 5).
        #2;
        reset = 1'b1;
        #1;
        check("arst_leds", {16'd0, leds}, 32'd0);
        check("arst_irq", {31'd0, timer_irq}, 32'd0);
        check("arst_q", q_dmem, 32'd0);
        wren         = 1'b0;
        address_dmem = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        bus_cycle(1'b0, 32'hFFFF_FFF2, 32'h0, 1'b1, 32'd0, "post_cnt");
        bus_cycle(1'b0, 32'hFFFF_FFF3, 32'h0, 1'b1, 32'hFFFF_FFFF, "post_cmp");
        bus_cycle(1'b0, 32'hFFFF_FFF4, 32'h0, 1'b1, 32'd0, "post_ctrl");
        bus_cycle(1'b0, 32'hFFFF_FFF5, 32'h0, 1'b1, 32'd0, "post_status");
        bus_cycle(1'b0, 32'hFFFF_FFF2, 32'h0, 1'b1, 32'd0, "post_cnt2");

        // One-shot: count stops at 2, enable clears, flag set, no irq.
        bus_cycle(1'b1, 32'hFFFF_FFF3, 32'd2, 1'b0, 32'h0, "os_cmp");
        bus_cycle(1'b1, 32'hFFFF_FFF4, 32'h1, 1'b0, 32'h0, "os_ctrl");
        for (int i = 0; i < 5; i++) begin
            bus_cycle(1'b0, 32'hFFFF_FFF2, 32'h0, 1'b1, (i > 2) ? 32'd2 : i,
                      $sformatf("os_cnt%0d", i));
            check($sformatf("os_irq%0d", i), {31'd0, timer_irq}, 32'd0);
        end
        bus_cycle(1'b0, 32'hFFFF_FFF4, 32'h0, 1'b1, 32'h4, "os_tctrl");
        bus_cycle(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "idle");

        check("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
